// File: rtl/uart_pkg.sv
// Shared UART Lite register map, status bit positions and the TX engine state encoding.
// Used by the word output engine and the loader.
package uart_pkg;

  typedef enum logic [3:0] {
    RX_FIFO  = 4'h0,
    STAT_REG = 4'h8
  } raddr_type;

  typedef enum logic [3:0] {
    TX_FIFO  = 4'h4,
    CTRL_REG = 4'hC
  } waddr_type;

  localparam int RX_VALID = 0;
  localparam int TX_FULL  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_W,
    ST_B
  } tx_state_type;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO, head word valid the cycle after the push edge; count is registered.
// A push while full is dropped even if a pop happens that cycle; a pop while empty is ignored.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their natural overflow
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers core words and writes them byte by byte to the UART Lite TX FIFO, polling STAT_REG before each byte.
// Push-to-arvalid is 2 cycles, 4 cycles per byte minimum; in_ready drops only when the word FIFO is full.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    err,
  output logic [3:0]              uart_axi_araddr,
  output logic                    uart_axi_arvalid,
  input  logic                    uart_axi_arready,
  input  logic [31:0]             uart_axi_rdata,
  input  logic [1:0]              uart_axi_rresp,
  input  logic                    uart_axi_rvalid,
  output logic                    uart_axi_rready,
  output logic [3:0]              uart_axi_awaddr,
  output logic                    uart_axi_awvalid,
  input  logic                    uart_axi_awready,
  output logic [31:0]             uart_axi_wdata,
  output logic [3:0]              uart_axi_wstrb,
  output logic                    uart_axi_wvalid,
  input  logic                    uart_axi_wready,
  input  logic [1:0]              uart_axi_bresp,
  input  logic                    uart_axi_bvalid,
  output logic                    uart_axi_bready
);

  localparam int WW  = 8 * WORD_BYTES;
  localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);

  tx_state_type   state;
  tx_state_type   state_next;
  logic [WW-1:0]  sreg;
  logic [BCW-1:0] byte_cnt;
  logic           aw_done;
  logic           w_done;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [WW-1:0]  fifo_head;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     cur_byte;
  logic           b_done;
  logic           unused_rd;

  word_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready        = !fifo_full;
  assign uart_axi_araddr = STAT_REG;
  assign uart_axi_awaddr = TX_FIFO;
  assign cur_byte        = MSB_FIRST ? sreg[WW-1 -: 8] : sreg[7:0];
  assign b_done          = (state == ST_B) && uart_axi_bvalid;
  assign unused_rd       = ^{uart_axi_rresp, uart_axi_rdata};

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    fifo_pop         = 1'b0;
    uart_axi_arvalid = 1'b0;
    uart_axi_rready  = 1'b0;
    uart_axi_awvalid = 1'b0;
    uart_axi_wvalid  = 1'b0;
    uart_axi_wdata   = '0;
    uart_axi_wstrb   = '0;
    uart_axi_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        uart_axi_arvalid = 1'b1;
        if (uart_axi_arready) state_next = ST_R;
      end
      ST_R: begin
        uart_axi_rready = 1'b1;
        if (uart_axi_rvalid) state_next = uart_axi_rdata[TX_FULL] ? ST_AR : ST_W;
      end
      ST_W: begin
        // AW and W complete independently; each valid is held only until its own ready
        uart_axi_awvalid = !aw_done;
        uart_axi_wvalid  = !w_done;
        uart_axi_wdata   = {24'b0, cur_byte};
        uart_axi_wstrb   = 4'b0001;
        if ((aw_done || uart_axi_awready) && (w_done || uart_axi_wready)) state_next = ST_B;
      end
      ST_B: begin
        uart_axi_bready = 1'b1;
        if (uart_axi_bvalid) state_next = (byte_cnt == LAST_BYTE) ? ST_IDLE : ST_AR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sreg     <= '0;
      byte_cnt <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (fifo_count != '0) || (state != ST_IDLE);
      if (fifo_pop) begin
        sreg     <= fifo_head;
        byte_cnt <= '0;
      end else if (b_done && (byte_cnt != LAST_BYTE)) begin
        sreg     <= MSB_FIRST ? (sreg << 8) : (sreg >> 8);
        byte_cnt <= byte_cnt + 1'b1;
      end
      if ((state == ST_W) && (state_next == ST_W)) begin
        aw_done <= aw_done || uart_axi_awready;
        w_done  <= w_done || uart_axi_wready;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      // A bad response is recorded but the byte is not retried
      if (b_done && (uart_axi_bresp != 2'b00)) err <= 1'b1;
    end
  end

endmodule
